k12a_inst_prefetch: RTL and testbench
=====================================

# k12a_inst_prefetch

Parametrised instruction register with prefetch queue. It assembles multi-byte instructions from the 8-bit data bus into a DEPTH-entry FIFO and presents the head instruction to the decoder. It also drives a paged operand address onto the address bus. It sits between the memory interface and the control unit, and lets fetch run ahead of execute.

## Interface
- INST_BYTES, 2, bytes per instruction (≥2); byte 0 is the most-significant byte.
- DEPTH, 2, FIFO entries (power of two, ≥2).
- ADDR_PAGE, 8'h80, high byte driven on addr_bus during an operand-address load.
- cpu_clock  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- byte_store  in  1  capture data_bus into the assembly lane selected by byte_idx.
- data_bus  in  8  instruction byte from memory.
- inst_pop  in  1  consume the head instruction.
- flush  in  1  discard the queue and any partial assembly (branch/interrupt).
- inst_addr_load  in  1  drive the operand address onto addr_bus.
- addr_bus  inout  16  {ADDR_PAGE, low byte of head}; high-Z otherwise.
- inst  out  8*INST_BYTES  head instruction; all zero when empty.
- inst_valid  out  1  head instruction present.
- full  out  1  count == DEPTH; the producer must not expect byte_store to be accepted.
- count  out  $clog2(DEPTH+1)  occupied entries.
- byte_idx  out  $clog2(INST_BYTES)  next lane to fill.

## Operation
- Assembly register holds INST_BYTES-1 bytes. byte_store with byte_idx=k<INST_BYTES-1 writes lane k and increments byte_idx.
- byte_store with byte_idx=INST_BYTES-1 pushes {lanes 0..n-2, data_bus} into the FIFO tail and wraps byte_idx to 0.
- byte_store is ignored entirely while full: no lane write and no byte_idx change, even for non-final bytes.
- inst_pop while inst_valid advances the head. inst_pop while empty is ignored.
- Push and pop in the same cycle: both occur and count is unchanged. Full with pop blocks the push, because byte_store is ignored when full.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is tracked separately to distinguish full from empty.
- flush has priority over byte_store and inst_pop in the same cycle. It sets count=0, byte_idx=0, assembly lanes=0 and both pointers=0.
- addr_bus = inst_addr_load ? {ADDR_PAGE, inst[7:0]} : 16'hzzzz. When empty, inst[7:0]=0, so the driven value is {ADDR_PAGE, 8'h00}.

## Timing
- Reset (asynchronous): count=0, full=0, inst_valid=0, inst=0, byte_idx=0, pointers=0, FIFO contents=0, addr_bus high-Z.
- Push latency: the final byte is stored at edge N; inst_valid and inst update after edge N. This gives one cycle of latency from byte presentation.
- Pop: the head advances at the edge where inst_pop is sampled. The next entry, or zero, is visible after that edge.
- full and count are registered-state decodes. They change only after an edge.
- addr_bus is purely combinational from inst_addr_load and the current head.
- Reset asserted mid-assembly discards partial lanes immediately.
- flush sampled at the edge with a final byte_store: the word is discarded and not pushed.

## Configuration
- K12A_INST_PREFETCH_BYPASS_EN defined: the bypass applies when the FIFO is empty, byte_store is high, byte_idx=INST_BYTES-1 and flush is low.
  - In that cycle, inst = {lanes, data_bus} combinationally and inst_valid=1.
  - If inst_pop is also high in that cycle, the word is consumed and not written to the FIFO (count stays 0). Otherwise it is pushed as normal.
  - addr_bus follows the bypassed inst.
- Not defined: no combinational path from data_bus/byte_store to inst/inst_valid. Only the registered latency described above applies.

## Test plan
- Reset mid-assembly: INST_BYTES=2, store 8'hA5, assert reset_n=0 → byte_idx=0, inst=0, inst_valid=0, addr_bus=Z.
- Assembly: store 8'h12 then 8'h34 → after the 2nd edge inst=16'h1234, inst_valid=1, count=1. inst_addr_load=1 → addr_bus=16'h8034.
- Fill/stall: DEPTH=2, push 16'h1111 and 16'h2222 → full=1. Then byte_store 8'h33 → byte_idx stays 0 and count stays 2. Pop → inst=16'h2222, full=0.
- Wrap-around: DEPTH=2, six push/pop pairs with values 16'h0001..16'h0006 → outputs appear in order and count never exceeds 2.
- Simultaneous push+pop at count=1, and flush+final-byte same cycle → count stays 1 in the first case. In the second, count=0, byte_idx=0, inst_valid=0.
- With BYPASS_EN, empty FIFO, bytes 8'hAB,8'hCD with inst_pop on the 2nd → inst=16'hABCD in the same cycle and count=0 afterwards. Without BYPASS_EN, inst_valid stays 0 that cycle.

Source files
------------

// File: rtl/k12a_inst_prefetch_if.sv
// k12a_inst_prefetch_if: byte stream from memory in, head instruction and queue status out to the decoder
interface k12a_inst_prefetch_if #(
  parameter int INST_BYTES = 2,
  parameter int DEPTH = 2
);
  logic byte_store;
  logic [7:0] data_bus;
  logic inst_pop;
  logic flush;
  logic inst_addr_load;
  logic [8*INST_BYTES-1:0] inst;
  logic inst_valid;
  logic full;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic [$clog2(INST_BYTES)-1:0] byte_idx;
  modport master (
    output byte_store, data_bus, inst_pop, flush, inst_addr_load,
    input inst, inst_valid, full, count, byte_idx
  );
  modport slave (
    input byte_store, data_bus, inst_pop, flush, inst_addr_load,
    output inst, inst_valid, full, count, byte_idx
  );
endinterface

// File: rtl/k12a_inst_prefetch.sv
// k12a_inst_prefetch: byte-assembling instruction prefetch FIFO; K12A_INST_PREFETCH_BYPASS_EN adds an empty-queue same-cycle bypass
module k12a_inst_prefetch #(
  parameter int INST_BYTES = 2,
  parameter int DEPTH = 2,
  parameter logic [7:0] ADDR_PAGE = 8'h80
) (
  input logic cpu_clock,
  input logic reset_n,
  k12a_inst_prefetch_if.slave bus,
  inout wire [15:0] addr_bus
);
  localparam int IW = 8*INST_BYTES;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int BW = $clog2(INST_BYTES);
  logic [IW-1:0] fifo [DEPTH];
  logic [INST_BYTES-2:0][7:0] lanes;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic [BW-1:0] idx, lane_sel;
  logic last, accept, empty, bypass, push, pop;
  logic [IW-1:0] word;
  assign last = idx == BW'(INST_BYTES-1);
  assign empty = cnt == '0;
  assign accept = bus.byte_store && cnt != CW'(DEPTH);
  assign word = {lanes, bus.data_bus};
  assign lane_sel = BW'(INST_BYTES-2) - idx;
`ifdef K12A_INST_PREFETCH_BYPASS_EN
  assign bypass = empty && bus.byte_store && last && !bus.flush;
`else
  assign bypass = 1'b0;
`endif
  assign push = accept && last && !(bypass && bus.inst_pop);
  assign pop = bus.inst_pop && !empty;
  assign bus.inst = bypass ? word : empty ? '0 : fifo[rd_ptr];
  assign bus.inst_valid = bypass || !empty;
  assign bus.full = cnt == CW'(DEPTH);
  assign bus.count = cnt;
  assign bus.byte_idx = idx;
  assign addr_bus = bus.inst_addr_load ? {ADDR_PAGE, bus.inst[7:0]} : 16'hzzzz;
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      idx <= '0;
      lanes <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else if (bus.flush) begin
      cnt <= '0;
      idx <= '0;
      lanes <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) idx <= last ? '0 : idx + 1'b1;
      if (accept && !last) lanes[lane_sel] <= bus.data_bus;
      if (push) begin
        fifo[wr_ptr] <= word;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_k12a_inst_prefetch.sv
// tb_k12a_inst_prefetch: scoreboard bench for the prefetch queue at INST_BYTES=2, DEPTH=2
module tb_k12a_inst_prefetch;
  logic cpu_clock = 1'b0;
  logic reset_n = 1'b0;
  wire [15:0] addr_bus;
  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];
  logic [15:0] exp_w;
  k12a_inst_prefetch_if #(.INST_BYTES(2), .DEPTH(2)) bus ();
  k12a_inst_prefetch #(.INST_BYTES(2), .DEPTH(2), .ADDR_PAGE(8'h80)) dut (
    .cpu_clock(cpu_clock),
    .reset_n(reset_n),
    .bus(bus),
    .addr_bus(addr_bus)
  );
  always #5 cpu_clock = ~cpu_clock;
  task automatic tick();
    @(posedge cpu_clock);
    #1;
  endtask
  task automatic put(input logic [7:0] d, input logic pop_i, input logic fl);
    bus.byte_store = 1'b1;
    bus.data_bus = d;
    bus.inst_pop = pop_i;
    bus.flush = fl;
    tick();
    bus.byte_store = 1'b0;
    bus.inst_pop = 1'b0;
    bus.flush = 1'b0;
  endtask
  task automatic push_word(input logic [15:0] w);
    put(w[15:8], 1'b0, 1'b0);
    put(w[7:0], 1'b0, 1'b0);
    if (sb.size() < 2) sb.push_back(w);
  endtask
  task automatic do_pop();
    bus.inst_pop = 1'b1;
    tick();
    bus.inst_pop = 1'b0;
  endtask
  task automatic test_reset();
    put(8'hA5, 1'b0, 1'b0);
    checks++; if (bus.byte_idx !== 1'b1) begin errors++; $display("FAIL reset_pre_idx got %0h want 1", bus.byte_idx); end
    reset_n = 1'b0;
    #1;
    checks++; if (bus.byte_idx !== 1'b0) begin errors++; $display("FAIL reset_idx got %0h want 0", bus.byte_idx); end
    checks++; if (bus.inst !== 16'h0000 || bus.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst got %h/%b want 0000/0", bus.inst, bus.inst_valid); end
    checks++; if (bus.count !== 2'd0 || bus.full !== 1'b0) begin errors++; $display("FAIL reset_count got %0d/%b want 0/0", bus.count, bus.full); end
    checks++; if (addr_bus !== 16'hzzzz && addr_bus !== 16'h0000) begin errors++; $display("FAIL reset_addr_z got %h want undriven", addr_bus); end
    bus.inst_addr_load = 1'b1;
    #1;
    checks++; if (addr_bus !== 16'h8000) begin errors++; $display("FAIL reset_addr_load got %h want 8000", addr_bus); end
    bus.inst_addr_load = 1'b0;
    #1;
    reset_n = 1'b1;
    sb.delete();
  endtask
  task automatic test_assembly();
    push_word(16'h1234);
    checks++; if (bus.inst !== sb[0] || bus.inst_valid !== 1'b1) begin errors++; $display("FAIL asm_inst got %h/%b want %h/1", bus.inst, bus.inst_valid, sb[0]); end
    checks++; if (bus.count !== 2'd1) begin errors++; $display("FAIL asm_count got %0d want 1", bus.count); end
    bus.inst_addr_load = 1'b1;
    #1;
    checks++; if (addr_bus !== {8'h80, sb[0][7:0]}) begin errors++; $display("FAIL asm_addr got %h want %h", addr_bus, {8'h80, sb[0][7:0]}); end
    bus.inst_addr_load = 1'b0;
    #1;
    checks++; if (addr_bus !== 16'hzzzz && addr_bus !== 16'h0000) begin errors++; $display("FAIL asm_addr_z got %h want undriven", addr_bus); end
    exp_w = sb.pop_front();
    checks++; if (bus.inst !== exp_w) begin errors++; $display("FAIL asm_pop got %h want %h", bus.inst, exp_w); end
    do_pop();
    checks++; if (bus.inst_valid !== 1'b0 || bus.inst !== 16'h0000 || bus.count !== 2'd0) begin errors++; $display("FAIL asm_empty got %b/%h/%0d want 0/0000/0", bus.inst_valid, bus.inst, bus.count); end
    do_pop();
    checks++; if (bus.count !== 2'd0) begin errors++; $display("FAIL asm_pop_empty got %0d want 0", bus.count); end
  endtask
  task automatic test_fill_stall();
    push_word(16'h1111);
    push_word(16'h2222);
    checks++; if (bus.full !== 1'b1 || bus.count !== 2'd2) begin errors++; $display("FAIL fill_full got %b/%0d want 1/2", bus.full, bus.count); end
    put(8'h33, 1'b0, 1'b0);
    checks++; if (bus.byte_idx !== 1'b0 || bus.count !== 2'd2) begin errors++; $display("FAIL fill_stall got %0h/%0d want 0/2", bus.byte_idx, bus.count); end
    exp_w = sb.pop_front();
    checks++; if (bus.inst !== exp_w) begin errors++; $display("FAIL fill_head got %h want %h", bus.inst, exp_w); end
    do_pop();
    checks++; if (bus.inst !== sb[0] || bus.full !== 1'b0) begin errors++; $display("FAIL fill_next got %h/%b want %h/0", bus.inst, bus.full, sb[0]); end
    push_word(16'h4455);
    exp_w = sb.pop_front();
    checks++; if (bus.inst !== exp_w) begin errors++; $display("FAIL fill_head2 got %h want %h", bus.inst, exp_w); end
    do_pop();
    exp_w = sb.pop_front();
    checks++; if (bus.inst !== exp_w) begin errors++; $display("FAIL fill_no_lane_write got %h want %h", bus.inst, exp_w); end
    do_pop();
  endtask
  task automatic test_wrap();
    push_word(16'h0001);
    for (int i = 2; i <= 6; i++) begin
      push_word(16'(i));
      checks++; if (bus.count !== 2'(sb.size())) begin errors++; $display("FAIL wrap_count_%0d got %0d want %0d", i, bus.count, sb.size()); end
      exp_w = sb.pop_front();
      checks++; if (bus.inst !== exp_w) begin errors++; $display("FAIL wrap_out_%0d got %h want %h", i, bus.inst, exp_w); end
      do_pop();
    end
    exp_w = sb.pop_front();
    checks++; if (bus.inst !== exp_w) begin errors++; $display("FAIL wrap_last got %h want %h", bus.inst, exp_w); end
    do_pop();
    checks++; if (bus.count !== 2'd0) begin errors++; $display("FAIL wrap_empty got %0d want 0", bus.count); end
  endtask
  task automatic test_back_to_back();
    push_word(16'hAA01);
    put(8'hAA, 1'b0, 1'b0);
    exp_w = sb.pop_front();
    checks++; if (bus.inst !== exp_w) begin errors++; $display("FAIL b2b_head got %h want %h", bus.inst, exp_w); end
    put(8'h02, 1'b1, 1'b0);
    sb.push_back(16'hAA02);
    checks++; if (bus.count !== 2'd1 || bus.inst !== sb[0]) begin errors++; $display("FAIL b2b_pushpop got %0d/%h want 1/%h", bus.count, bus.inst, sb[0]); end
    put(8'h77, 1'b0, 1'b0);
    put(8'h88, 1'b0, 1'b1);
    sb.delete();
    checks++; if (bus.count !== 2'd0 || bus.byte_idx !== 1'b0 || bus.inst_valid !== 1'b0) begin errors++; $display("FAIL flush_final got %0d/%0h/%b want 0/0/0", bus.count, bus.byte_idx, bus.inst_valid); end
  endtask
  task automatic test_bypass();
    put(8'hAB, 1'b0, 1'b0);
    bus.byte_store = 1'b1;
    bus.data_bus = 8'hCD;
    bus.inst_pop = 1'b1;
    #1;
`ifdef K12A_INST_PREFETCH_BYPASS_EN
    checks++; if (bus.inst !== 16'hABCD || bus.inst_valid !== 1'b1) begin errors++; $display("FAIL bypass_comb got %h/%b want abcd/1", bus.inst, bus.inst_valid); end
    tick();
    bus.byte_store = 1'b0;
    bus.inst_pop = 1'b0;
    checks++; if (bus.count !== 2'd0) begin errors++; $display("FAIL bypass_count got %0d want 0", bus.count); end
`else
    checks++; if (bus.inst_valid !== 1'b0 || bus.inst !== 16'h0000) begin errors++; $display("FAIL nobypass_comb got %h/%b want 0000/0", bus.inst, bus.inst_valid); end
    tick();
    bus.byte_store = 1'b0;
    bus.inst_pop = 1'b0;
    sb.push_back(16'hABCD);
    checks++; if (bus.count !== 2'd1 || bus.inst !== sb[0]) begin errors++; $display("FAIL nobypass_push got %0d/%h want 1/%h", bus.count, bus.inst, sb[0]); end
    exp_w = sb.pop_front();
    do_pop();
    checks++; if (bus.count !== 2'd0) begin errors++; $display("FAIL nobypass_drain got %0d want 0 after %h", bus.count, exp_w); end
`endif
  endtask
  initial begin
    bus.byte_store = 1'b0;
    bus.data_bus = 8'h00;
    bus.inst_pop = 1'b0;
    bus.flush = 1'b0;
    bus.inst_addr_load = 1'b0;
    #12;
    reset_n = 1'b1;
    tick();
    test_reset();
    test_assembly();
    test_fill_stall();
    test_wrap();
    test_back_to_back();
    test_bypass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
